bin2bcd_seq: RTL and testbench

Parametrised, iterative binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock, with a valid/ready handshake on input and output. It also provides a registered full BCD result and a combinational per-digit selector, so display logic can pick any decimal digit of an arbitrary-width binary value. It sits between measurement/counter logic (speed, satellite count, time) and the 7-segment/digit drivers.

---
 rtl/bin2bcd_pkg.sv | 15 +
 rtl/bin2bcd_seq_if.sv | 36 +++
 rtl/bin2bcd_seq_add3.sv | 14 +
 rtl/bin2bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD
// converter.
//   state_e : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_W   : bits per decimal digit
package bin2bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bus of the binary-to-BCD converter.
//   valid_i/ready_o/bin_i : input handshake and binary operand
//   valid_o/ready_i       : result handshake
//   bcd_o/overflow_o      : packed BCD result (nibble 0 = ones), overflow flag
//   sel_i/digit_o         : decimal digit selector and the selected nibble
// Signal names are written from the converter's point of view.
//   slave  : converter side
//   master : producer/consumer side
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH_P  = 8,
  parameter int unsigned DIGITS_P = 3
);
  localparam int unsigned SELW_P = (DIGITS_P > 1) ? $clog2(DIGITS_P) : 1;

  logic                        valid_i;
  logic                        ready_o;
  logic [WIDTH_P-1:0]          bin_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [BCD_W*DIGITS_P-1:0]   bcd_o;
  logic                        overflow_o;
  logic [SELW_P-1:0]           sel_i;
  logic [BCD_W-1:0]            digit_o;

  modport slave (
    input  valid_i, bin_i, ready_i, sel_i,
    output ready_o, valid_o, bcd_o, overflow_o, digit_o
  );

  modport master (
    output valid_i, bin_i, ready_i, sel_i,
    input  ready_o, valid_o, bcd_o, overflow_o, digit_o
  );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, one decimal digit.
//   x_i : current BCD digit
//   y_o : x_i + 3 when x_i >= 5, otherwise x_i
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x_i,
  output logic [BCD_W-1:0] y_o
);
  always_comb begin
    y_o = x_i;
    if (x_i >= BCD_W'(5)) y_o = x_i + BCD_W'(3);
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative binary-to-BCD converter (shift-add-3), one bit per
// clock, valid/ready on both sides.
//   clk_i    : system clock, rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : slave side of bin2bcd_seq_if (operand in, BCD result out,
//              overflow flag, combinational digit selector)
// Result is value mod 10^DIGITS_P; overflow_o flags value >= 10^DIGITS_P.
// bcd_o/overflow_o hold until the next completion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH_P  = 8,
  parameter int unsigned DIGITS_P = 3
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  bin2bcd_seq_if.slave     bus
);
  localparam int unsigned SELW_P = (DIGITS_P > 1) ? $clog2(DIGITS_P) : 1;
  localparam int unsigned BCDW   = BCD_W * DIGITS_P;
  localparam int unsigned CNTW   = $clog2(WIDTH_P + 1);

  state_e              state_q;
  logic                ready_q;
  logic                valid_q;
  logic [BCDW-1:0]     bcd_q;
  logic                ovf_q;
  logic [CNTW-1:0]     cnt_q;
  logic [WIDTH_P-1:0]  sh_q;
  logic [BCDW-1:0]     acc_q;
  logic                ovf_acc_q;

  logic [BCDW-1:0]     acc_corr;
  logic [BCDW-1:0]     acc_d;
  logic [WIDTH_P-1:0]  sh_d;
  logic                ovf_acc_d;
  logic                last;
  logic [BCD_W-1:0]    digit;

  for (genvar g = 0; g < DIGITS_P; g++) begin : g_add3
    bcd_add3 u_add3 (
      .x_i (acc_q[g*BCD_W +: BCD_W]),
      .y_o (acc_corr[g*BCD_W +: BCD_W])
    );
  end

  // One double-dabble step: shift {corrected BCD, binary} left by one.
  // The bit leaving the top corrected digit is a carry past 10^DIGITS_P.
  always_comb begin
    acc_d     = {acc_corr[BCDW-2:0], sh_q[WIDTH_P-1]};
    sh_d      = sh_q << 1;
    ovf_acc_d = ovf_acc_q | acc_corr[BCDW-1];
    last      = (cnt_q == CNTW'(WIDTH_P - 1));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            sh_q      <= bus.bin_i;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q     <= acc_d;
          sh_q      <= sh_d;
          ovf_acc_q <= ovf_acc_d;
          cnt_q     <= cnt_q + CNTW'(1);
          if (last) begin
            bcd_q   <= acc_d;
            ovf_q   <= ovf_acc_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    digit = '0;
    for (int unsigned k = 0; k < DIGITS_P; k++) begin
      if (32'(bus.sel_i) == k) digit = bcd_q[k*BCD_W +: BCD_W];
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.valid_o    = valid_q;
  assign bus.bcd_o      = bcd_q;
  assign bus.overflow_o = ovf_q;
  assign bus.digit_o    = digit;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations (8/3, 10/3, 16/5) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_bin2bcd_seq;

  localparam int unsigned PW [3] = '{8, 10, 16};
  localparam int unsigned PD [3] = '{3, 3, 5};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Drivers
  logic        vin [3];
  logic        rin [3];
  int unsigned bin [3];
  int unsigned sel [3];

  // Observed outputs
  logic        ro  [3];
  logic        vo  [3];
  logic        ovo [3];
  logic [19:0] bo  [3];
  logic [3:0]  dg  [3];

  bin2bcd_seq_if #(.WIDTH_P(8),  .DIGITS_P(3)) if0 ();
  bin2bcd_seq_if #(.WIDTH_P(10), .DIGITS_P(3)) if1 ();
  bin2bcd_seq_if #(.WIDTH_P(16), .DIGITS_P(5)) if2 ();

  bin2bcd_seq #(.WIDTH_P(8),  .DIGITS_P(3)) dut0 (.clk_i(clk), .reset_ni(rst_n), .bus(if0.slave));
  bin2bcd_seq #(.WIDTH_P(10), .DIGITS_P(3)) dut1 (.clk_i(clk), .reset_ni(rst_n), .bus(if1.slave));
  bin2bcd_seq #(.WIDTH_P(16), .DIGITS_P(5)) dut2 (.clk_i(clk), .reset_ni(rst_n), .bus(if2.slave));

  assign if0.valid_i = vin[0];
  assign if1.valid_i = vin[1];
  assign if2.valid_i = vin[2];
  assign if0.ready_i = rin[0];
  assign if1.ready_i = rin[1];
  assign if2.ready_i = rin[2];
  assign if0.bin_i   = bin[0][7:0];
  assign if1.bin_i   = bin[1][9:0];
  assign if2.bin_i   = bin[2][15:0];
  assign if0.sel_i   = sel[0][1:0];
  assign if1.sel_i   = sel[1][1:0];
  assign if2.sel_i   = sel[2][2:0];

  assign ro[0] = if0.ready_o;    assign ro[1] = if1.ready_o;    assign ro[2] = if2.ready_o;
  assign vo[0] = if0.valid_o;    assign vo[1] = if1.valid_o;    assign vo[2] = if2.valid_o;
  assign ovo[0] = if0.overflow_o; assign ovo[1] = if1.overflow_o; assign ovo[2] = if2.overflow_o;
  assign bo[0] = {8'h0, if0.bcd_o};
  assign bo[1] = {8'h0, if1.bcd_o};
  assign bo[2] = if2.bcd_o;
  assign dg[0] = if0.digit_o;    assign dg[1] = if1.digit_o;    assign dg[2] = if2.digit_o;

  // Decimal digits of v, least significant first, truncated to d digits.
  function automatic logic [19:0] to_bcd(input int unsigned v, input int unsigned d);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int unsigned k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int unsigned pow10(input int unsigned d);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < d; k++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: accept in idle, result WIDTH_P edges later,
  // held until the consumer takes it.
  logic        m_ready [3];
  logic        m_valid [3];
  logic        m_ovf   [3];
  logic [19:0] m_bcd   [3];
  int unsigned m_cnt   [3];
  int unsigned m_val   [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_ready[i] <= 1'b1;
        m_valid[i] <= 1'b0;
        m_ovf[i]   <= 1'b0;
        m_bcd[i]   <= '0;
        m_cnt[i]   <= 0;
        m_val[i]   <= 0;
      end else if (m_cnt[i] != 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) begin
          m_valid[i] <= 1'b1;
          m_bcd[i]   <= to_bcd(m_val[i], PD[i]);
          m_ovf[i]   <= (m_val[i] >= pow10(PD[i]));
        end
      end else if (m_valid[i]) begin
        if (rin[i]) begin
          m_valid[i] <= 1'b0;
          m_ready[i] <= 1'b1;
        end
      end else if (vin[i]) begin
        m_val[i]   <= bin[i] % (32'd1 << PW[i]);
        m_cnt[i]   <= PW[i];
        m_ready[i] <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [3:0] ed;
      ed = 4'h0;
      if (sel[i] < PD[i]) ed = m_bcd[i][4*sel[i] +: 4];
      chk($sformatf("cyc_ready[%0d]", i), ro[i], m_ready[i]);
      chk($sformatf("cyc_valid[%0d]", i), vo[i], m_valid[i]);
      chk($sformatf("cyc_bcd[%0d]", i), bo[i], m_bcd[i]);
      chk($sformatf("cyc_ovf[%0d]", i), ovo[i], m_ovf[i]);
      chk($sformatf("cyc_digit[%0d]", i), dg[i], ed);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one value for one cycle to an idle instance, then wait for the
  // result and check the acceptance-to-valid latency.
  task automatic send(input int inst, input int unsigned val);
    int unsigned c;
    vin[inst] = 1'b1;
    bin[inst] = val;
    tick();
    vin[inst] = 1'b0;
    c = 0;
    while (!vo[inst] && c < 40) begin
      tick();
      c++;
    end
    chk($sformatf("valid_seen[%0d]", inst), vo[inst], 1'b1);
    chk($sformatf("latency[%0d]", inst), c, PW[inst]);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0;
      rin[i] = 1'b1;
      bin[i] = 0;
      sel[i] = 0;
    end

    // Model pins
    chk("pin_99",    32'(to_bcd(99, 3)),    32'h099);
    chk("pin_1023",  32'(to_bcd(1023, 3)),  32'h023);
    chk("pin_65535", 32'(to_bcd(65535, 5)), 32'h65535);

    tick();
    tick();
    chk("rst_ready", ro[0], 1'b1);
    chk("rst_valid", vo[0], 1'b0);
    chk("rst_bcd",   bo[0], 20'h0);
    chk("rst_ovf",   ovo[0], 1'b0);
    rst_n = 1'b1;
    tick();

    send(0, 32'h63);
    chk("bcd_63", bo[0], 20'h099);
    chk("ovf_63", ovo[0], 1'b0);
    sel[0] = 0; #1 chk("dig_63_s0", dg[0], 4'd9);
    sel[0] = 1; #1 chk("dig_63_s1", dg[0], 4'd9);
    sel[0] = 2; #1 chk("dig_63_s2", dg[0], 4'd0);
    tick();

    send(0, 32'h19);
    chk("bcd_19", bo[0], 20'h025);
    sel[0] = 1; #1 chk("dig_19_s1", dg[0], 4'd2);
    sel[0] = 0; #1 chk("dig_19_s0", dg[0], 4'd5);
    sel[0] = 3; #1 chk("dig_19_s3", dg[0], 4'd0);
    tick();
    send(0, 32'hFF);
    chk("bcd_ff", bo[0], 20'h255);
    chk("ovf_ff", ovo[0], 1'b0);
    tick();
    send(0, 32'h00);
    chk("bcd_00", bo[0], 20'h000);
    tick();

    send(1, 1023);
    chk("bcd_1023", bo[1], 20'h023);
    chk("ovf_1023", ovo[1], 1'b1);
    tick();
    send(1, 999);
    chk("bcd_999", bo[1], 20'h999);
    chk("ovf_999", ovo[1], 1'b0);
    tick();

    send(2, 65535);
    chk("bcd_65535", bo[2], 20'h65535);
    chk("ovf_65535", ovo[2], 1'b0);
    tick();

    // Backpressure: result must hold, new requests ignored.
    rin[0] = 1'b0;
    send(0, 42);
    for (int n = 0; n < 20; n++) begin
      vin[0] = 1'b1;
      bin[0] = $urandom_range(0, 255);
      tick();
      chk("bp_valid", vo[0], 1'b1);
      chk("bp_bcd",   bo[0], 20'h042);
      chk("bp_ready", ro[0], 1'b0);
    end
    vin[0] = 1'b0;
    rin[0] = 1'b1;
    tick();
    chk("bp_rel_ready", ro[0], 1'b1);
    chk("bp_rel_valid", vo[0], 1'b0);

    // Reset in the middle of a conversion.
    vin[0] = 1'b1;
    bin[0] = 32'hC8;
    tick();
    vin[0] = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ro[0], 1'b1);
    chk("mid_rst_valid", vo[0], 1'b0);
    chk("mid_rst_bcd",   bo[0], 20'h0);
    chk("mid_rst_ovf",   ovo[0], 1'b0);
    chk("mid_rst_bcd2",  bo[2], 20'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(0, 200);
    chk("bcd_200", bo[0], 20'h200);
    tick();

    // Randomized traffic on all three instances.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 3; i++) begin
        vin[i] = ($urandom_range(0, 3) == 0);
        bin[i] = $urandom_range(0, (1 << PW[i]) - 1);
        rin[i] = ($urandom_range(0, 2) != 0);
        sel[i] = (i == 2) ? $urandom_range(0, 7) : $urandom_range(0, 3);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0;
      rin[i] = 1'b1;
    end
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
